// File: rtl/dds_pkg.sv
// Shared DDS definitions: tuning-word width, sweep FSM states, sweep modes and step directions.
package dds_pkg;

  localparam int unsigned FREQ_WIDTH = 32;

  localparam logic MODE_SINGLE   = 1'b0;
  localparam logic MODE_TRIANGLE = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDown
  } sweep_state_e;

endpackage

// File: rtl/dds_sweep_step.sv
// Combinational clamped add/subtract for one sweep step; the result never passes the limit,
// and a zero step jumps straight to it.
module dds_sweep_step
  import dds_pkg::*;
#(
  parameter int unsigned FreqWidth = FREQ_WIDTH
) (
  input  logic [FreqWidth-1:0] cur,
  input  logic [FreqWidth-1:0] step,
  input  logic [FreqWidth-1:0] limit,
  input  logic                 direction,
  output logic [FreqWidth-1:0] next,
  output logic                 at_limit
);

  logic [FreqWidth:0] sum;
  logic [FreqWidth:0] diff;

  always_comb begin
    sum      = {1'b0, cur} + {1'b0, step};
    diff     = {1'b0, cur} - {1'b0, step};
    next     = limit;
    at_limit = 1'b0;
    if (direction == DIR_UP) begin
      at_limit = (cur >= limit);
      // Carry-out or reaching the limit both clamp.
      if ((step != '0) && !sum[FreqWidth] && (sum[FreqWidth-1:0] < limit)) begin
        next = sum[FreqWidth-1:0];
      end
    end else begin
      at_limit = (cur <= limit);
      if ((step != '0) && !diff[FreqWidth] && (diff[FreqWidth-1:0] > limit)) begin
        next = diff[FreqWidth-1:0];
      end
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller feeding the DDS tuning word; single or triangle sweeps.
// Define DDS_SWEEP_CNT_EN to add the sweep_cnt_o completed-sweep/turnaround counter.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned FreqWidth  = FREQ_WIDTH,
  parameter int unsigned DwellWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  mode_i,
  input  logic [FreqWidth-1:0]  f_start_i,
  input  logic [FreqWidth-1:0]  f_stop_i,
  input  logic [FreqWidth-1:0]  f_step_i,
  input  logic [DwellWidth-1:0] dwell_i,
  output logic [FreqWidth-1:0]  freq_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef DDS_SWEEP_CNT_EN
  ,
  output logic [15:0]           sweep_cnt_o
`endif
);

  sweep_state_e          state_q, state_d;
  logic [FreqWidth-1:0]  freq_q, freq_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DwellWidth-1:0] dwell_cnt_q, dwell_cnt_d;
  logic                  mode_q, mode_d;
  logic [FreqWidth-1:0]  f_start_q, f_start_d;
  logic [FreqWidth-1:0]  f_stop_q, f_stop_d;
  logic [FreqWidth-1:0]  f_step_q, f_step_d;
  logic [DwellWidth-1:0] dwell_q, dwell_d;

  logic [FreqWidth-1:0]  up_next, down_next;
  logic                  up_at_limit, down_at_limit;
  logic                  degen;
  logic                  start_ok;
  logic                  dwell_done;

  dds_sweep_step #(
    .FreqWidth(FreqWidth)
  ) u_step_up (
    .cur      (freq_q),
    .step     (f_step_q),
    .limit    (f_stop_q),
    .direction(DIR_UP),
    .next     (up_next),
    .at_limit (up_at_limit)
  );

  dds_sweep_step #(
    .FreqWidth(FreqWidth)
  ) u_step_down (
    .cur      (freq_q),
    .step     (f_step_q),
    .limit    (f_start_q),
    .direction(DIR_DOWN),
    .next     (down_next),
    .at_limit (down_at_limit)
  );

  // An empty range pins the output at f_start for the whole sweep.
  assign degen      = (f_stop_q <= f_start_q);
  assign start_ok   = start_i && !abort_i;
  assign dwell_done = (dwell_cnt_q == dwell_q);

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    mode_d      = mode_q;
    f_start_d   = f_start_q;
    f_stop_d    = f_stop_q;
    f_step_d    = f_step_q;
    dwell_d     = dwell_q;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          mode_d      = mode_i;
          f_start_d   = f_start_i;
          f_stop_d    = f_stop_i;
          f_step_d    = f_step_i;
          dwell_d     = dwell_i;
          freq_d      = f_start_i;
          busy_d      = 1'b1;
          dwell_cnt_d = '0;
          state_d     = StUp;
        end
      end
      StUp, StDown: begin
        if (abort_i) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (!dwell_done) begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end else begin
          dwell_cnt_d = '0;
          if (state_q == StUp) begin
            if (!up_at_limit) begin
              freq_d = up_next;
            end else if (mode_q == MODE_SINGLE) begin
              state_d = StIdle;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = StDown;
              if (!degen) freq_d = down_next;
            end
          end else begin
            if (!down_at_limit) begin
              freq_d = down_next;
            end else begin
              state_d = StUp;
              if (!degen) freq_d = up_next;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      freq_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dwell_cnt_q <= '0;
      mode_q      <= MODE_SINGLE;
      f_start_q   <= '0;
      f_stop_q    <= '0;
      f_step_q    <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dwell_cnt_q <= dwell_cnt_d;
      mode_q      <= mode_d;
      f_start_q   <= f_start_d;
      f_stop_q    <= f_stop_d;
      f_step_q    <= f_step_d;
      dwell_q     <= dwell_d;
    end
  end

  assign freq_o = freq_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

`ifdef DDS_SWEEP_CNT_EN
  logic [15:0] sweep_cnt_q, sweep_cnt_d;
  logic        turn;

  // In single mode the only "turnaround" is the completing edge, so this also counts done pulses.
  assign turn = !abort_i && dwell_done &&
                (((state_q == StUp) && up_at_limit) || ((state_q == StDown) && down_at_limit));

  always_comb begin
    sweep_cnt_d = sweep_cnt_q;
    if ((state_q == StIdle) && start_ok) begin
      sweep_cnt_d = '0;
    end else if (turn) begin
      sweep_cnt_d = sweep_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sweep_cnt_q <= '0;
    end else begin
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  assign sweep_cnt_o = sweep_cnt_q;
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed cases plus random sweeps against a
// per-hold-period reference model. Counter checks follow DDS_SWEEP_CNT_EN.
module tb_dds_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        mode;
  logic [31:0] f_start;
  logic [31:0] f_stop;
  logic [31:0] f_step;
  logic [15:0] dwell;
  logic [31:0] freq;
  logic        busy;
  logic        done;
`ifdef DDS_SWEEP_CNT_EN
  logic [15:0] sweep_cnt;
`endif

  int total = 0;
  int bad   = 0;

  localparam int MaxCyc = 256;
  logic [31:0] exp_f[MaxCyc];
  bit          exp_b[MaxCyc];
  bit          exp_d[MaxCyc];
  int          exp_c[MaxCyc];

  dds_sweep_ctrl dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .abort_i  (abort),
    .mode_i   (mode),
    .f_start_i(f_start),
    .f_stop_i (f_stop),
    .f_step_i (f_step),
    .dwell_i  (dwell),
    .freq_o   (freq),
    .busy_o   (busy),
    .done_o   (done)
`ifdef DDS_SWEEP_CNT_EN
    ,
    .sweep_cnt_o(sweep_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [31:0] step_up(input logic [31:0] v, input logic [31:0] st,
                                          input logic [31:0] fe);
    longint s;
    s = longint'(v) + longint'(st);
    if (st == 0 || s >= longint'(fe)) return fe;
    return 32'(s);
  endfunction

  function automatic logic [31:0] step_down(input logic [31:0] v, input logic [31:0] st,
                                            input logic [31:0] fs);
    longint s;
    s = longint'(v) - longint'(st);
    if (st == 0 || s <= longint'(fs)) return fs;
    return 32'(s);
  endfunction

  // Walks hold periods: each value is shown dwell+1 cycles, then the next value is chosen.
  task automatic build_model(input bit md, input logic [31:0] fs, input logic [31:0] fe,
                             input logic [31:0] st, input int dw, input int n);
    int          k;
    int          cnt;
    logic [31:0] v;
    bit          up;
    bit          degen;
    k     = 0;
    cnt   = 0;
    v     = fs;
    up    = 1'b1;
    degen = (fe <= fs);
    while (k < n) begin
      for (int i = 0; i <= dw && k < n; i++) begin
        exp_f[k] = v; exp_b[k] = 1'b1; exp_d[k] = 1'b0; exp_c[k] = cnt; k++;
      end
      if (!md) begin
        if (degen || v == fe) begin
          cnt++;
          for (int j = 0; k < n; j++) begin
            exp_f[k] = v; exp_b[k] = 1'b0; exp_d[k] = (j == 0); exp_c[k] = cnt; k++;
          end
        end else begin
          v = step_up(v, st, fe);
        end
      end else if (degen) begin
        cnt++;
      end else if (up) begin
        if (v == fe) begin up = 1'b0; cnt++; v = step_down(v, st, fs); end
        else v = step_up(v, st, fe);
      end else begin
        if (v == fs) begin up = 1'b1; cnt++; v = step_up(v, st, fe); end
        else v = step_down(v, st, fs);
      end
    end
  endtask

  task automatic check_cycle(input string tag, input int k);
    check({tag, ".freq"}, k, freq, exp_f[k]);
    check({tag, ".busy"}, k, {31'd0, busy}, {31'd0, exp_b[k]});
    check({tag, ".done"}, k, {31'd0, done}, {31'd0, exp_d[k]});
`ifdef DDS_SWEEP_CNT_EN
    check({tag, ".cnt"}, k, {16'd0, sweep_cnt}, exp_c[k] & 32'hFFFF);
`endif
  endtask

  // Starts a sweep, scrambles the config inputs afterwards, and ends with abort or reset.
  task automatic run_sweep(input string tag, input bit md, input logic [31:0] fs,
                           input logic [31:0] fe, input logic [31:0] st, input int dw,
                           input int n, input bit end_reset);
    build_model(md, fs, fe, st, dw, n);
    @(negedge clk);
    mode = md; f_start = fs; f_stop = fe; f_step = st; dwell = 16'(dw);
    start = 1'b1; abort = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      mode = 1'($urandom); f_start = $urandom; f_stop = $urandom; f_step = $urandom;
      dwell = 16'($urandom);
      check_cycle(tag, k);
      if (exp_b[k]) start = 1'($urandom_range(0, 1));
    end
    if (end_reset) begin
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0;
      check({tag, ".rst_freq"}, n, freq, 32'd0);
      check({tag, ".rst_busy"}, n, {31'd0, busy}, 32'd0);
      check({tag, ".rst_done"}, n, {31'd0, done}, 32'd0);
`ifdef DDS_SWEEP_CNT_EN
      check({tag, ".rst_cnt"}, n, {16'd0, sweep_cnt}, 32'd0);
`endif
    end else begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      check({tag, ".abort_freq"}, n, freq, exp_f[n-1]);
      check({tag, ".abort_busy"}, n, {31'd0, busy}, 32'd0);
      check({tag, ".abort_done"}, n, {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset.freq", 0, freq, 32'd0);
    check("reset.busy", 0, {31'd0, busy}, 32'd0);
    check("reset.done", 0, {31'd0, done}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle.busy", 1, {31'd0, busy}, 32'd0);

    run_sweep("t1_single", 1'b0, 32'd100, 32'd130, 32'd10, 1, 12, 1'b0);
    run_sweep("t2_clamp", 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 6, 1'b0);
    run_sweep("t3_tri", 1'b1, 32'd0, 32'd20, 32'd8, 0, 40, 1'b0);

    // Abort at 110, then a start/abort collision in IDLE.
    @(negedge clk);
    mode = 1'b0; f_start = 32'd100; f_stop = 32'd130; f_step = 32'd10; dwell = 16'd1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t4.pre_abort_freq", 2, freq, 32'd110);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("t4.abort_busy", 3, {31'd0, busy}, 32'd0);
    check("t4.abort_done", 3, {31'd0, done}, 32'd0);
    check("t4.abort_freq", 3, freq, 32'd110);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t4.hold_freq", 5, freq, 32'd110);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    check("t4.collide_busy", 6, {31'd0, busy}, 32'd0);
    check("t4.collide_freq", 6, freq, 32'd110);

    run_sweep("t5_tri_rst", 1'b1, 32'd0, 32'd20, 32'd8, 0, 9, 1'b1);
    run_sweep("t5_after", 1'b0, 32'd100, 32'd130, 32'd10, 1, 12, 1'b0);
    run_sweep("t6_step0", 1'b0, 32'd5, 32'd50, 32'd0, 2, 10, 1'b0);
    run_sweep("t6_degen", 1'b0, 32'd5, 32'd3, 32'd1, 2, 6, 1'b0);
    run_sweep("t6_degen_tri", 1'b1, 32'd5, 32'd3, 32'd1, 1, 12, 1'b0);

    for (int r = 0; r < 10; r++) begin
      logic [31:0] fs;
      logic [31:0] fe;
      logic [31:0] st;
      int          span;
      bit          md;
      int          dw;
      fs   = $urandom;
      span = int'($urandom_range(0, 3000));
      md   = 1'($urandom_range(0, 1));
      dw   = int'($urandom_range(0, 3));
      fe   = ((32'hFFFF_FFFF - fs) < 32'(span)) ? 32'hFFFF_FFFF : fs + 32'(span);
      if ($urandom_range(0, 5) == 0) fe = fs >> 1;
      case ($urandom_range(0, 4))
        0:       st = 32'd0;
        1:       st = $urandom;
        default: st = $urandom_range(32'(span / 40 + 1), 32'(span + 1));
      endcase
      run_sweep($sformatf("rand%0d", r), md, fs, fe, st, dw, 200, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep controller directly upstream of dds_generator. Its freq_o drives dds_generator.freq_i, so the generator's phase-increment word steps linearly from a start to a stop tuning word. Each step is held for a programmable number of clocks. Supports a single up-sweep or a continuous triangle (up/down) sweep, with start/abort control and a completion pulse.

Parameters:
FREQ_WIDTH, 32, width of tuning words (matches the generator's phase accumulator).
DWELL_WIDTH, 16, width of the dwell counter.

Ports:
clk_i  input  1  system clock, rising edge.
rst_i  input  1  reset, synchronous, active-low (asserted when 0).
start_i  input  1  start request; sampled only in IDLE.
abort_i  input  1  stop sweep; return to IDLE.
mode_i  input  1  0 = single up-sweep, 1 = continuous triangle; latched on start.
f_start_i  input  FREQ_WIDTH  first tuning word; latched on start.
f_stop_i  input  FREQ_WIDTH  last tuning word; latched on start.
f_step_i  input  FREQ_WIDTH  increment per step; latched on start.
dwell_i  input  DWELL_WIDTH  each value is held dwell_i+1 clocks; latched on start.
freq_o  output  FREQ_WIDTH  tuning word to dds_generator, registered.
busy_o  output  1  high while sweeping, registered.
done_o  output  1  one-cycle pulse when a single sweep completes, registered.

Behaviour:
- Reset: rst_i==0 at a clock edge sets freq_o=0, busy_o=0, done_o=0, state IDLE, dwell counter 0 and latched config 0. This applies mid-sweep too and overrides all other inputs.
- States:
  - IDLE: freq_o holds its last value.
  - UP: step toward f_stop.
  - DOWN: step toward f_start (triangle mode only).
- Start: IDLE with start_i=1 and abort_i=0 at edge N.
  - Config is latched.
  - freq_o=f_start, busy_o=1, dwell counter=0, state UP.
  - All of the above are visible after edge N (1-cycle latency).
- start_i is ignored when not in IDLE.
- Dwell: the counter increments every cycle while busy. When it equals the latched dwell, the next edge applies a step and clears the counter.
- UP step: next = cur + step, computed in FREQ_WIDTH+1 bits.
  - If next >= f_stop, or the sum carries out, freq_o = f_stop (clamped).
  - If step == 0, freq_o jumps directly to f_stop.
- At f_stop, once its dwell expires:
  - Mode 0: state goes to IDLE, busy_o=0, done_o=1 for one cycle; freq_o stays f_stop.
  - Mode 1: state goes to DOWN and the first down-step is applied on that same edge.
- DOWN step: next = cur − step. If it borrows or next <= f_start, freq_o = f_start; step == 0 jumps to f_start. At f_start, once its dwell expires: state goes to UP and the first up-step is applied. The triangle repeats until abort; no done pulse.
- Degenerate start with f_stop <= f_start:
  - freq_o=f_start for one dwell period, then behaves as "at f_stop".
  - Mode 0: done pulse, freq_o stays f_start.
  - Mode 1: holds f_start indefinitely, busy=1.
- Abort (any state, abort_i=1): next edge goes to IDLE, busy_o=0, no done pulse, freq_o holds its current value. When start_i and abort_i are both high in IDLE, abort wins and the sweep does not start.
- freq_o changes only on step edges or on start; there are no glitch values between steps.

Optional Feature:
Macro DDS_SWEEP_CNT_EN.
- When defined: adds output sweep_cnt_o (16 bits), reset to 0 and cleared on start.
  - Mode 0: +1 when done_o fires.
  - Mode 1: +1 on each turnaround at f_stop or f_start.
  - Wraps 0xFFFF to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package dds_pkg: FREQ_WIDTH constant (shared with dds_generator), state enum {IDLE, UP, DOWN}, MODE_SINGLE/MODE_TRIANGLE constants.
- One natural sub-module: dds_sweep_step, a combinational clamped add/subtract. Inputs: cur, step, limit, direction. Outputs: next, at_limit. It holds the carry/borrow and step==0 rules so they can be unit-tested on their own.

Test Plan:
1. Reset, then start; mode=0, f_start=100, f_stop=130, step=10, dwell=1 -> freq_o 100,100,110,110,120,120,130,130; busy drops and done_o pulses once on the cycle after the second 130.
2. Clamp and overflow: f_start=0xFFFFFFF0, f_stop=0xFFFFFFFF, step=0x20, dwell=0 -> freq_o 0xFFFFFFF0 then 0xFFFFFFFF (no wrap to 0x10), then done.
3. Triangle: mode=1, f_start=0, f_stop=20, step=8, dwell=0 -> freq_o repeats 0,8,16,20,12,4,0,8,...; done_o never asserts; with DDS_SWEEP_CNT_EN, sweep_cnt_o increments at each 20 and each 0.
4. Abort mid-sweep at freq_o=110 in test 1 -> next cycle busy=0, done=0, freq_o=110 held; start_i during busy has no effect; start with abort in the same cycle leaves IDLE.
5. rst_i=0 for one clock mid-triangle -> freq_o=0, busy=0, done=0 on that edge; a new start afterwards behaves as in test 1.
6. Degenerate cases: step=0 with f_start=5, f_stop=50, dwell=2 -> 5 for 3 clocks, then 50 for 3 clocks, then done; f_stop=3 < f_start=5 in mode 0 -> 5 for dwell+1 clocks, then done.
